// File: rtl/wr_stream_framer_pkg.sv
// Shared types and default sizing for the write-stream framer.
package wr_stream_framer_pkg;

  localparam int unsigned DATA_W_DEF = 256;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned BEAT_BYTES = DATA_W_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/wr_stream_framer_if.sv
// Valid/ready beat bundle; master drives the beat, slave returns ready.
interface wr_stream_framer_if
  import wr_stream_framer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] keep;
  logic                last;
  logic                valid;
  logic                ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);

endinterface

// File: rtl/wr_stream_framer_axis_skid_buf.sv
// Two-entry registered output buffer: head register drives the output,
// skid register absorbs one beat while the head is stalled.
module axis_skid_buf #(
  parameter int unsigned DATA_W = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic                out_valid,
  input  logic                out_ready
);

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic                last;
  } beat_t;

  beat_t head_q, head_d, skid_q, skid_d;
  logic  head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  beat_t in_beat;
  logic  push, pop;

  assign in_beat  = '{data: in_data, keep: in_keep, last: in_last};
  assign in_ready = ~skid_valid_q;
  assign push     = in_valid & ~skid_valid_q;
  assign pop      = head_valid_q & out_ready;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    // push is only possible with the skid empty, so pop+push never touches skid
    if (pop) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        head_d = in_beat;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push) begin
      if (head_valid_q) begin
        skid_d       = in_beat;
        skid_valid_d = 1'b1;
      end else begin
        head_d       = in_beat;
        head_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_data  = head_q.data;
  assign out_keep  = head_q.keep;
  assign out_last  = head_q.last;
  assign out_valid = head_valid_q;

endmodule

// File: rtl/wr_stream_framer.sv
// Frames a byte-counted accelerator stream toward a DDR write DMA:
// one command pulse, beats with tail strobes, then a completion pulse.
module wr_stream_framer
  import wr_stream_framer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Start,
  input  logic [CNT_W-1:0]    Num_Bytes,
  wr_stream_framer_if.slave   s_stream,
  wr_stream_framer_if.master  m_stream,
  output logic                DMA_Valid,
  output logic                Busy,
  output logic                Introut
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned SHIFT  = $clog2(KEEP_W);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [SHIFT-1:0]   rem_q, rem_d;

  logic [SHIFT-1:0]   start_rem;
  logic [CNT_W-1:0]   start_beats;
  logic [KEEP_W-1:0]  last_keep;
  logic               stream_open, buf_ready, push, pop, in_is_last;

  // Shift-based divide keeps the beat count within CNT_W for any Num_Bytes
  assign start_rem   = Num_Bytes[SHIFT-1:0];
  assign start_beats = (Num_Bytes >> SHIFT) + CNT_W'(start_rem != '0);

  assign stream_open = (state_q == ST_STREAM) && (in_cnt_q < beats_q);
  assign push        = s_stream.valid & stream_open & buf_ready;
  assign pop         = m_stream.valid & m_stream.ready;
  assign in_is_last  = (in_cnt_q + CNT_W'(1)) == beats_q;

  assign s_stream.ready = stream_open & buf_ready;

  always_comb begin
    last_keep = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      last_keep[i] = (rem_q == '0) || (i < 32'(rem_q));
    end
  end

  axis_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (s_stream.data),
    .in_keep   (in_is_last ? last_keep : '1),
    .in_last   (in_is_last),
    .in_valid  (s_stream.valid & stream_open),
    .in_ready  (buf_ready),
    .out_data  (m_stream.data),
    .out_keep  (m_stream.keep),
    .out_last  (m_stream.last),
    .out_valid (m_stream.valid),
    .out_ready (m_stream.ready)
  );

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    rem_d    = rem_q;
    in_cnt_d = in_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          beats_d  = start_beats;
          rem_d    = start_rem;
          in_cnt_d = '0;
          state_d  = (Num_Bytes != '0) ? ST_CMD : ST_DONE;
        end
      end
      ST_CMD: state_d = ST_STREAM;
      ST_STREAM: begin
        if (push) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (pop && m_stream.last) begin
          state_d = ST_DONE;
        end else if (push && in_is_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && m_stream.last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      beats_q  <= '0;
      rem_q    <= '0;
      in_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      rem_q    <= rem_d;
      in_cnt_q <= in_cnt_d;
    end
  end

  assign DMA_Valid = (state_q == ST_CMD);
  assign Busy      = (state_q != ST_IDLE);
  assign Introut   = (state_q == ST_DONE);

endmodule

// File: tb/tb_wr_stream_framer.sv
// Directed bench for wr_stream_framer: per-frame logging of handshakes,
// compared against hand-computed beat counts, strobes and pulse timing.
module tb_wr_stream_framer;

  localparam int unsigned DW   = 256;
  localparam int unsigned CW   = 32;
  localparam int unsigned NONE = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          Start;
  logic [CW-1:0] Num_Bytes;
  logic          DMA_Valid, Busy, Introut;

  wr_stream_framer_if #(.DATA_W(DW)) s_if ();
  wr_stream_framer_if #(.DATA_W(DW)) m_if ();

  wr_stream_framer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Num_Bytes (Num_Bytes),
    .s_stream  (s_if),
    .m_stream  (m_if),
    .DMA_Valid (DMA_Valid),
    .Busy      (Busy),
    .Introut   (Introut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [DW-1:0] got_data [16];
  logic [31:0]   got_keep [16];
  logic          got_last [16];
  int unsigned   got_rel  [16];
  int unsigned   n_got, s_acc, dma_cnt, dma_rel, intr_cnt, intr_rel, busy_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int unsigned t, input int unsigned i);
    return (DW'(t) << 32) | DW'(i);
  endfunction

  task automatic check_quiet(input string p);
    chk({p, "_s_ready"},   s_if.ready, 0);
    chk({p, "_m_valid"},   m_if.valid, 0);
    chk({p, "_m_last"},    m_if.last,  0);
    chk({p, "_m_data"},    m_if.data,  0);
    chk({p, "_m_keep"},    m_if.keep,  0);
    chk({p, "_dma_valid"}, DMA_Valid,  0);
    chk({p, "_busy"},      Busy,       0);
    chk({p, "_introut"},   Introut,    0);
  endtask

  // Called at a negedge; r = cycles since the Start cycle.
  task automatic run_frame(input int unsigned tag, input int unsigned nbytes,
                           input int unsigned stall_at, input int unsigned stall_len,
                           input int unsigned restart_at, input int unsigned reset_at);
    int unsigned src_idx;
    logic        s_fire;
    n_got = 0; s_acc = 0; dma_cnt = 0; dma_rel = 0;
    intr_cnt = 0; intr_rel = 0; busy_cnt = 0; src_idx = 0;
    for (int k = 0; k < 16; k++) begin
      got_data[k] = '0; got_keep[k] = '0; got_last[k] = 1'b0; got_rel[k] = 0;
    end
    s_if.valid = 1'b1;
    s_if.data  = pat(tag, 0);
    for (int unsigned r = 0; r < 100; r++) begin
      if (r == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        repeat (2) begin
          @(posedge clk); @(negedge clk);
          if (Introut) intr_cnt++;
        end
        rst_n = 1'b1;
        break;
      end
      Start      = (r == 0) || (r == restart_at);
      Num_Bytes  = (r == restart_at) ? 32'd999 : nbytes;
      m_if.ready = !(r >= stall_at && r < stall_at + stall_len);
      s_fire = s_if.valid && s_if.ready;
      if (s_fire) s_acc++;
      if (m_if.valid && m_if.ready && n_got < 16) begin
        got_data[n_got] = m_if.data;
        got_keep[n_got] = m_if.keep;
        got_last[n_got] = m_if.last;
        got_rel[n_got]  = r;
        n_got++;
      end
      if (DMA_Valid) begin dma_cnt++; dma_rel = r; end
      if (Introut)   begin intr_cnt++; intr_rel = r; end
      if (Busy) busy_cnt++;
      if (stall_len != 0 && r == stall_at + 5) begin
        chk("stall_s_ready", s_if.ready, 0);
        chk("stall_buffered", s_acc - n_got, 2);
        chk("stall_head_beat", m_if.data, pat(tag, 1));
      end
      @(posedge clk); @(negedge clk);
      if (s_fire) begin
        src_idx++;
        s_if.data = pat(tag, src_idx);
      end
      if (intr_cnt != 0 && r >= intr_rel + 2) break;
    end
    Start      = 1'b0;
    m_if.ready = 1'b1;
  endtask

  task automatic verify(input string nm, input int unsigned tag, input int unsigned exp_beats,
                        input logic [31:0] exp_last_keep, input int unsigned exp_dma,
                        input int unsigned exp_intr_rel, input int unsigned exp_busy,
                        input bit contig);
    chk({nm, "_beats"},    n_got,    exp_beats);
    chk({nm, "_dma_cnt"},  dma_cnt,  exp_dma);
    if (exp_dma != 0) chk({nm, "_dma_rel"}, dma_rel, 1);
    chk({nm, "_intr_cnt"}, intr_cnt, 1);
    chk({nm, "_intr_rel"}, intr_rel, exp_intr_rel);
    chk({nm, "_busy_cyc"}, busy_cnt, exp_busy);
    for (int unsigned k = 0; k < exp_beats; k++) begin
      chk($sformatf("%s_data%0d", nm, k), got_data[k], pat(tag, k));
      chk($sformatf("%s_keep%0d", nm, k), got_keep[k],
          (k == exp_beats - 1) ? exp_last_keep : 32'hFFFF_FFFF);
      chk($sformatf("%s_last%0d", nm, k), got_last[k], k == exp_beats - 1);
      if (contig) chk($sformatf("%s_rel%0d", nm, k), got_rel[k], 3 + k);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    Start      = 1'b0;
    Num_Bytes  = '0;
    s_if.data  = '0;
    s_if.keep  = '1;
    s_if.last  = 1'b0;
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;

    // Start on the very first edge after release
    run_frame(1, 96, NONE, 0, NONE, NONE);
    verify("f96", 1, 3, 32'hFFFF_FFFF, 1, 6, 6, 1'b1);

    run_frame(2, 70, NONE, 0, NONE, NONE);
    verify("f70", 2, 3, 32'h0000_003F, 1, 6, 6, 1'b1);

    run_frame(3, 0, NONE, 0, NONE, NONE);
    verify("f0", 3, 0, 32'h0, 0, 1, 1, 1'b0);

    run_frame(4, 320, 4, 10, NONE, NONE);
    verify("f320", 4, 10, 32'hFFFF_FFFF, 1, 23, 23, 1'b0);

    run_frame(5, 96, NONE, 0, 3, NONE);
    verify("restart", 5, 3, 32'hFFFF_FFFF, 1, 6, 6, 1'b1);

    run_frame(6, 160, NONE, 0, NONE, 5);
    chk("abort_beats", n_got, 2);
    chk("abort_intr", intr_cnt, 0);

    run_frame(7, 64, NONE, 0, NONE, NONE);
    verify("f64", 7, 2, 32'hFFFF_FFFF, 1, 5, 5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
